// File: rtl/datapath_out_ctrl_if.sv
// CPU-cycle handshake and datapath-control bundle for datapath_out_ctrl.
interface datapath_out_ctrl_if;
    // cycle request and bus status
    logic CYC_START;
    logic CYC_RW;
    logic CYC_SRC;
    logic PORT16;
    logic AS_;
    logic FIFO_EMPTY;
    // data-bus enables, mux selects and handshake results
    logic DOEH_;
    logic DOEL_;
    logic F2CPUL;
    logic F2CPUH;
    logic S2CPU;
    logic BRIDGEOUT;
    logic PAS;
    logic FIFO_POP;
    logic CPU_ACK;
    logic BERR;

    // requester side: issues cycles, observes the datapath controls
    modport master (
        output CYC_START, CYC_RW, CYC_SRC, PORT16, AS_, FIFO_EMPTY,
        input  DOEH_, DOEL_, F2CPUL, F2CPUH, S2CPU, BRIDGEOUT,
        input  PAS, FIFO_POP, CPU_ACK, BERR
    );

    // controller side
    modport slave (
        input  CYC_START, CYC_RW, CYC_SRC, PORT16, AS_, FIFO_EMPTY,
        output DOEH_, DOEL_, F2CPUL, F2CPUH, S2CPU, BRIDGEOUT,
        output PAS, FIFO_POP, CPU_ACK, BERR
    );
endinterface

// File: rtl/datapath_out_ctrl.sv
// Read-data output controller: sequences register reads and FIFO reads onto
// the CPU data bus, with a bounded FIFO wait that ends in a bus error.
module datapath_out_ctrl #(
    parameter int unsigned WAIT_MAX = 64
) (
    input  logic         SCLK,
    input  logic         RST,
    datapath_out_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REGRD = 3'd1,
        FWAIT = 3'd2,
        LATCH = 3'd3,
        DRIVE = 3'd4,
        TERM  = 3'd5
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             src_q;
    logic             src_d;
    logic             port16_q;
    logic             port16_d;
    logic             timeout;

    logic doeh_d;
    logic doel_d;
    logic f2cpul_d;
    logic f2cpuh_d;
    logic s2cpu_d;
    logic bridgeout_d;
    logic pas_d;
    logic fifo_pop_d;
    logic cpu_ack_d;
    logic berr_d;

    // State, wait counter and captured cycle attributes
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= '0;
            src_q    <= 1'b0;
            port16_q <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_cnt_d;
            src_q    <= src_d;
            port16_q <= port16_d;
        end
    end

    // Next state; address-strobe release outranks FIFO arrival and timeout
    always_comb begin
        next_state = state;
        wait_cnt_d = wait_cnt;
        src_d      = src_q;
        port16_d   = port16_q;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.CYC_START && bus.CYC_RW) begin
                    src_d      = bus.CYC_SRC;
                    port16_d   = bus.PORT16;
                    wait_cnt_d = '0;
                    if (!bus.CYC_SRC) begin
                        next_state = REGRD;
                    end else if (!bus.FIFO_EMPTY) begin
                        next_state = LATCH;
                    end else begin
                        next_state = FWAIT;
                    end
                end
            end
            REGRD, DRIVE: begin
                if (bus.AS_) begin
                    next_state = TERM;
                end
            end
            FWAIT: begin
                if (bus.AS_) begin
                    next_state = TERM;
                end else if (!bus.FIFO_EMPTY) begin
                    next_state = LATCH;
                end else if (wait_cnt == CNT_LAST) begin
                    next_state = TERM;
                    timeout    = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt + CNT_W'(1);
                end
            end
            LATCH: begin
                next_state = bus.AS_ ? TERM : DRIVE;
            end
            TERM: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode for the state being entered; the source bit keeps the
    // register and FIFO selects mutually exclusive by construction
    always_comb begin
        doeh_d      = 1'b1;
        doel_d      = 1'b1;
        f2cpul_d    = 1'b0;
        f2cpuh_d    = 1'b0;
        s2cpu_d     = 1'b0;
        bridgeout_d = 1'b0;
        pas_d       = 1'b0;
        fifo_pop_d  = 1'b0;
        cpu_ack_d   = 1'b0;
        berr_d      = timeout;
        case (next_state)
            REGRD: begin
                if (!src_d) begin
                    s2cpu_d   = 1'b1;
                    doeh_d    = 1'b0;
                    doel_d    = 1'b0;
                    cpu_ack_d = (state == REGRD);
                end
            end
            LATCH: begin
                pas_d      = 1'b1;
                fifo_pop_d = 1'b1;
            end
            DRIVE: begin
                if (src_d) begin
                    f2cpul_d  = 1'b1;
                    doeh_d    = 1'b0;
                    cpu_ack_d = (state == DRIVE);
                    if (port16_d) begin
                        bridgeout_d = 1'b1;
                    end else begin
                        f2cpuh_d = 1'b1;
                        doel_d   = 1'b0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs; reset releases the bus immediately
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            bus.DOEH_     <= 1'b1;
            bus.DOEL_     <= 1'b1;
            bus.F2CPUL    <= 1'b0;
            bus.F2CPUH    <= 1'b0;
            bus.S2CPU     <= 1'b0;
            bus.BRIDGEOUT <= 1'b0;
            bus.PAS       <= 1'b0;
            bus.FIFO_POP  <= 1'b0;
            bus.CPU_ACK   <= 1'b0;
            bus.BERR      <= 1'b0;
        end else begin
            bus.DOEH_     <= doeh_d;
            bus.DOEL_     <= doel_d;
            bus.F2CPUL    <= f2cpul_d;
            bus.F2CPUH    <= f2cpuh_d;
            bus.S2CPU     <= s2cpu_d;
            bus.BRIDGEOUT <= bridgeout_d;
            bus.PAS       <= pas_d;
            bus.FIFO_POP  <= fifo_pop_d;
            bus.CPU_ACK   <= cpu_ack_d;
            bus.BERR      <= berr_d;
        end
    end

endmodule

// File: tb/tb_datapath_out_ctrl.sv
// Self-checking bench for datapath_out_ctrl: vector table, directed corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_datapath_out_ctrl;

    localparam int unsigned WAIT_MAX = 4;
    localparam int unsigned N_VEC    = 12;
    localparam int unsigned N_RAND   = 3000;

    // output bit order: DOEH_ DOEL_ F2CPUL F2CPUH S2CPU BRIDGEOUT PAS FIFO_POP CPU_ACK BERR
    typedef logic [9:0] outs_t;

    localparam outs_t O_IDLE     = 10'b11_0000_0000;
    localparam outs_t O_LATCH    = 10'b11_0000_1100;
    localparam outs_t O_REGRD    = 10'b00_0010_0000;
    localparam outs_t O_REGRD_AK = 10'b00_0010_0010;
    localparam outs_t O_DRV32    = 10'b00_1100_0000;
    localparam outs_t O_DRV32_AK = 10'b00_1100_0010;
    localparam outs_t O_DRV16    = 10'b01_1001_0000;
    localparam outs_t O_DRV16_AK = 10'b01_1001_0010;
    localparam outs_t O_BERR     = 10'b11_0000_0001;

    typedef struct {
        logic  start;
        logic  rw;
        logic  src;
        logic  p16;
        logic  as_n;
        logic  empty;
        outs_t exp;
        string name;
    } vec_t;

    typedef enum int {M_IDLE, M_REGRD, M_FWAIT, M_LATCH, M_DRIVE, M_TERM} mst_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    mst_t  m_st;
    int    m_n;
    logic  m_p16;
    outs_t m_exp;

    vec_t vecs [N_VEC];

    always #5 clk = ~clk;

    datapath_out_ctrl_if bus ();

    datapath_out_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .SCLK (clk),
        .RST  (rst),
        .bus  (bus.slave)
    );

    function automatic outs_t dut_outs();
        return {bus.DOEH_, bus.DOEL_, bus.F2CPUL, bus.F2CPUH, bus.S2CPU,
                bus.BRIDGEOUT, bus.PAS, bus.FIFO_POP, bus.CPU_ACK, bus.BERR};
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic set_in(input logic start, input logic rw, input logic src,
                          input logic p16, input logic as_n, input logic empty);
        bus.CYC_START  = start;
        bus.CYC_RW     = rw;
        bus.CYC_SRC    = src;
        bus.PORT16     = p16;
        bus.AS_        = as_n;
        bus.FIFO_EMPTY = empty;
    endtask

    task automatic model_reset();
        m_st  = M_IDLE;
        m_n   = 0;
        m_p16 = 1'b0;
        m_exp = O_IDLE;
    endtask

    // One clock of the reference: decide the next phase from the inputs,
    // then list what the bus must show during that phase
    task automatic model_step();
        mst_t nx   = m_st;
        logic berr = 1'b0;
        case (m_st)
            M_IDLE: if (bus.CYC_START && bus.CYC_RW) begin
                m_p16 = bus.PORT16;
                if (!bus.CYC_SRC)        nx = M_REGRD;
                else if (!bus.FIFO_EMPTY) nx = M_LATCH;
                else                      nx = M_FWAIT;
            end
            M_REGRD, M_DRIVE: if (bus.AS_) nx = M_TERM;
            M_FWAIT: begin
                if (bus.AS_)              nx = M_TERM;
                else if (!bus.FIFO_EMPTY) nx = M_LATCH;
                else if (m_n >= int'(WAIT_MAX)) begin
                    nx   = M_TERM;
                    berr = 1'b1;
                end
            end
            M_LATCH: nx = bus.AS_ ? M_TERM : M_DRIVE;
            default: nx = M_IDLE;
        endcase
        m_n  = (nx == m_st) ? m_n + 1 : 1;
        m_st = nx;
        case (m_st)
            M_REGRD: m_exp = (m_n >= 2) ? O_REGRD_AK : O_REGRD;
            M_LATCH: m_exp = O_LATCH;
            M_DRIVE: begin
                if (m_p16) m_exp = (m_n >= 2) ? O_DRV16_AK : O_DRV16;
                else       m_exp = (m_n >= 2) ? O_DRV32_AK : O_DRV32;
            end
            default: m_exp = O_IDLE;
        endcase
        m_exp[0] = berr;
    endtask

    // Advance one clock, then compare against the model away from the edge
    task automatic tick();
        outs_t o;
        @(posedge clk);
        model_step();
        #1;
        o = dut_outs();
        check("model", o, m_exp);
        check("sel_exclusive", {9'b0, o[5] & (o[7] | o[6])}, 10'b0);
    endtask

    task automatic step_chk(input string name, input logic start, input logic rw,
                            input logic src, input logic p16, input logic as_n,
                            input logic empty, input outs_t exp);
        set_in(start, rw, src, p16, as_n, empty);
        tick();
        check(name, dut_outs(), exp);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LATCH,    "f32_latch"};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_DRV32,    "f32_drive1"};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_DRV32_AK, "f32_drive_ack"};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_IDLE,     "f32_term"};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_IDLE,     "f32_idle"};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_LATCH,    "f16_latch"};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, O_DRV16,    "f16_drive1"};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_DRV16_AK, "f16_ack_start_ignored"};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_IDLE,     "f16_term"};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, O_IDLE,     "f16_idle"};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_IDLE,     "write_ignored"};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, O_IDLE,     "write_still_idle"};

        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        model_reset();
        #12;
        check("reset_state", dut_outs(), O_IDLE);
        @(negedge clk);
        rst = 1'b0;

        // table-driven FIFO reads and write rejection
        for (int i = 0; i < int'(N_VEC); i++) begin
            step_chk(vecs[i].name, vecs[i].start, vecs[i].rw, vecs[i].src,
                     vecs[i].p16, vecs[i].as_n, vecs[i].empty, vecs[i].exp);
        end

        // register read held for five cycles
        step_chk("regrd_c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_REGRD);
        for (int k = 2; k <= 5; k++) begin
            step_chk("regrd_ack", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_REGRD_AK);
        end
        step_chk("regrd_term", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_IDLE);
        step_chk("regrd_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, O_IDLE);

        // FIFO wait timeout -> single BERR pulse
        step_chk("to_fwait1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_IDLE);
        for (int k = 2; k <= int'(WAIT_MAX); k++) begin
            step_chk("to_fwait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_IDLE);
        end
        step_chk("to_berr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_BERR);
        step_chk("to_berr_clear", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_IDLE);

        // FIFO word arrives in the timeout cycle -> LATCH, no BERR
        step_chk("late_fwait1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_IDLE);
        for (int k = 2; k <= int'(WAIT_MAX); k++) begin
            step_chk("late_fwait", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_IDLE);
        end
        step_chk("late_latch", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LATCH);
        step_chk("late_abort_term", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_IDLE);
        step_chk("late_idle", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_IDLE);

        // strobe released while waiting for the FIFO
        step_chk("abort_fwait", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_IDLE);
        step_chk("abort_term", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_IDLE);
        step_chk("abort_idle", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_IDLE);

        // reset pulse in the middle of DRIVE, then a clean FIFO read
        step_chk("rd_latch", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LATCH);
        step_chk("rd_drive", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_DRV32);
        step_chk("rd_drive_ack", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_DRV32_AK);
        #2;
        rst = 1'b1;
        #1;
        check("reset_mid_drive", dut_outs(), O_IDLE);
        model_reset();
        #1;
        rst = 1'b0;
        step_chk("post_rst_idle", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_IDLE);
        step_chk("post_rst_latch", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LATCH);
        step_chk("post_rst_drive", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_DRV32);
        step_chk("post_rst_ack", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_DRV32_AK);
        step_chk("post_rst_term", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_IDLE);
        step_chk("post_rst_back", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, O_IDLE);

        // randomized traffic against the reference model
        for (int i = 0; i < int'(N_RAND); i++) begin
            set_in(1'($urandom_range(3) == 0),
                   1'($urandom_range(4) != 0),
                   1'($urandom_range(1)),
                   1'($urandom_range(1)),
                   1'($urandom_range(4) == 0),
                   1'($urandom_range(9) < 7));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
